cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of functional-unit writeback requesters.
REQ-002 SHALL have parameter NUM_CDB, default 2: number of CDB broadcast ports, with 1 <= NUM_CDB <= NUM_REQ.
REQ-003 SHALL have parameter ROB_IDX, default 5: ROB index width.
REQ-004 SHALL have parameter PRF_IDX, default 6: physical register index width.
REQ-005 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous assert and active-low (0 = reset).
REQ-007 SHALL have port flush  input  1: backend flush.
REQ-008 SHALL have port req_valid  input  NUM_REQ: per-requester result valid.
REQ-009 SHALL have port req_ready  output  NUM_REQ: per-requester grant; a transfer occurs when valid and ready are both 1.
REQ-010 SHALL have port req_pkt  input  NUM_REQ x cdb_pkt_t: {rob_id[ROB_IDX], rd_phy[PRF_IDX], rd_arch[5], rd_value[32]}.
REQ-011 SHALL have port cdb_valid  output  NUM_CDB: CDB port valid.
REQ-012 SHALL have port cdb_pkt  output  NUM_CDB x cdb_pkt_t: broadcast payload.
REQ-013 SHALL have port conflict_cnt  output  32: saturating count of cycles in which more than NUM_CDB requesters were valid.

Function
REQ-014 SHALL grant up to NUM_CDB valid requesters per cycle, searching round-robin from rr_ptr upward with modulo-NUM_REQ wrap.
REQ-015 SHALL compute req_ready combinationally in the same cycle; req_ready SHALL be 0 for any requester whose req_valid is 0.
REQ-016 SHALL assign the k-th granted requester in search order to CDB port k, so the lowest port is filled first.
REQ-017 SHALL register each granted payload, so it appears on cdb_pkt[k] with cdb_valid[k]=1 exactly one cycle after the handshake (latency 1).
REQ-018 SHALL drive cdb_valid[k]=0 in every cycle that follows a cycle with fewer than k+1 grants; cdb_pkt is don't-care when its valid bit is 0.
REQ-019 SHALL update rr_ptr after a cycle with at least one grant to (index of last granted requester + 1) mod NUM_REQ.
REQ-020 SHALL leave rr_ptr unchanged after a cycle with no grants.
REQ-021 SHALL guarantee that a continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
REQ-022 SHALL force all req_ready to 0 and perform no transfer while flush=1.
REQ-023 SHALL drive cdb_valid all-0 in the cycle after flush=1, discarding in-flight registered results.
REQ-024 SHALL preserve rr_ptr across a flush.
REQ-025 SHALL increment conflict_cnt when popcount(req_valid) > NUM_CDB and flush=0, and SHALL saturate it at 32'hFFFFFFFF.
REQ-026 SHALL impose the requester obligation that req_pkt stays stable while req_valid=1 and req_ready=0; the bench SHALL check this by assertion.

Reset
REQ-027 SHALL, while rst=0, clear cdb_valid to 0, cdb_pkt to 0, rr_ptr to 0 and conflict_cnt to 0, regardless of clk.
REQ-028 SHALL hold req_ready at 0 while rst=0.
REQ-029 SHALL grant on the first rising edge after rst deasserts, with the search starting from requester 0.

Structure
REQ-030 SHALL define cdb_pkt_t and the NUM_REQ/NUM_CDB defaults in the shared uop_types / cpu_params packages.
REQ-031 SHALL instantiate one sub-module, rr_multi_grant (combinational NUM_CDB-way round-robin picker producing grant vector and per-port index); all state SHALL reside in cdb_arbiter.

Verification
REQ-032 Bench SHALL cover: req_valid=4'b1111 for 2 cycles after reset -> cycle 1 grants 0,1 on ports 0,1; cycle 2 grants 2,3; rr_ptr=0; conflict_cnt=2.
REQ-033 Bench SHALL cover: only req 3 valid with rob_id=7, rd_value=32'hDEADBEEF -> next cycle cdb_valid=2'b01, cdb_pkt[0].rob_id=7, rd_value=32'hDEADBEEF; rr_ptr=0.
REQ-034 Bench SHALL cover: rr_ptr=3 and req_valid=4'b1001 -> grants 3 then 0 (wrap); port 0 carries req 3, port 1 carries req 0; rr_ptr becomes 1.
REQ-035 Bench SHALL cover: flush=1 with req_valid=4'b0110 -> req_ready=0; next cycle cdb_valid=0; rr_ptr and conflict_cnt unchanged.
REQ-036 Bench SHALL cover: rst asserted mid-stream, asynchronous to clk -> cdb_valid=0 and conflict_cnt=0 immediately; after release, the first grant goes to req 0.
REQ-037 Bench SHALL cover: conflict_cnt preloaded at 32'hFFFFFFFE with 3 valid for 3 cycles -> value stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB packet type, default sizes and width helpers
package cdb_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int NUM_CDB_DEF = 2;
    localparam int ROB_IDX_DEF = 5;
    localparam int PRF_IDX_DEF = 6;
    localparam int ARCH_IDX    = 5;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic [ROB_IDX_DEF-1:0] rob_id;
        logic [PRF_IDX_DEF-1:0] rd_phy;
        logic [ARCH_IDX-1:0]    rd_arch;
        logic [DATA_W-1:0]      rd_value;
    } cdb_pkt_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int pkt_w(input int rob, input int prf);
        return rob + prf + ARCH_IDX + DATA_W;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// rr_multi_grant: combinational round-robin picker granting up to M of N requesters
module rr_multi_grant #(
    parameter int N  = 4,
    parameter int M  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [IW-1:0]        ptr,
    output logic [N-1:0]         grant,
    output logic [M-1:0]         port_vld,
    output logic [M-1:0][IW-1:0] port_idx,
    output logic [IW-1:0]        last_idx
);

    int          cnt;
    int          s;
    logic [IW-1:0] j;

    // Walk requesters from ptr upward with wrap; the k-th hit lands on port k
    always_comb begin
        grant    = '0;
        port_vld = '0;
        port_idx = '0;
        last_idx = ptr;
        cnt      = 0;
        s        = 0;
        j        = '0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            j = IW'(s >= N ? s - N : s);
            if (valid[j] && cnt < M) begin
                grant[j] = 1'b1;
                for (int k = 0; k < M; k++) begin
                    if (cnt == k) begin
                        port_vld[k] = 1'b1;
                        port_idx[k] = j;
                    end
                end
                last_idx = j;
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: multi-port round-robin writeback arbiter driving registered CDB ports
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int ROB_IDX = ROB_IDX_DEF,
    parameter int PRF_IDX = PRF_IDX_DEF
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  flush,
    input  logic [NUM_REQ-1:0]                                    req_valid,
    output logic [NUM_REQ-1:0]                                    req_ready,
    input  logic [NUM_REQ-1:0][pkt_w(ROB_IDX, PRF_IDX)-1:0]       req_pkt,
    output logic [NUM_CDB-1:0]                                    cdb_valid,
    output logic [NUM_CDB-1:0][pkt_w(ROB_IDX, PRF_IDX)-1:0]       cdb_pkt,
    output logic [31:0]                                           conflict_cnt
);

    localparam int IW = idx_w(NUM_REQ);

    logic [IW-1:0]              rr_ptr;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_CDB-1:0]         port_vld;
    logic [NUM_CDB-1:0][IW-1:0] port_idx;
    logic [IW-1:0]              last_idx;
    logic                       conflict;

    rr_multi_grant #(
        .N  (NUM_REQ),
        .M  (NUM_CDB),
        .IW (IW)
    ) u_pick (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .port_vld (port_vld),
        .port_idx (port_idx),
        .last_idx (last_idx)
    );

    assign req_ready = (rst && !flush) ? grant : '0;
    assign conflict  = !flush && ($countones(req_valid) > NUM_CDB);

    // Register granted payloads onto CDB ports, advance the pointer, count oversubscription
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid    <= '0;
            cdb_pkt      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            cdb_valid <= flush ? '0 : port_vld;
            for (int k = 0; k < NUM_CDB; k++)
                if (port_vld[k]) cdb_pkt[k] <= req_pkt[port_idx[k]];
            if (!flush && |grant)
                rr_ptr <= last_idx == IW'(NUM_REQ - 1) ? '0 : last_idx + IW'(1);
            if (conflict && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule
